// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared control definitions for the multi-cycle RV32I core: opcodes, FSM states,
// ALU operation codes, datapath mux selects and the opcode class / control word records.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BEQ      = 4'd9,
      ST_JAL      = 4'd10,
      ST_TRAP     = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   typedef struct packed {
      logic is_mem;
      logic is_store;
      logic is_r;
      logic is_i;
      logic is_beq;
      logic is_jal;
      logic is_illegal;
   } op_class_t;

   // *_rdy fields are qualified by mem_ready at the output, branch by Zero
   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic [1:0] res;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       retire;
      logic       retire_rdy;
      logic       ir_rdy;
      logic       pc_upd;
      logic       pc_upd_rdy;
      logic       branch;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_classify.sv
// Combinational opcode classifier; shared between the multi-cycle FSM and pipelined decode.
module ctrl_opcode_classify
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output op_class_t  cls
);

   always_comb begin
      cls            = '0;
      cls.is_mem     = (op == OP_LW) || (op == OP_SW);
      cls.is_store   = (op == OP_SW);
      cls.is_r       = (op == OP_R);
      cls.is_i       = (op == OP_I);
      cls.is_beq     = (op == OP_BEQ);
      cls.is_jal     = (op == OP_JAL);
      cls.is_illegal = !(cls.is_mem || cls.is_r || cls.is_i || cls.is_beq || cls.is_jal);
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, memory and ALU
// phases over a shared ALU and unified memory port, trapping on unsupported opcodes.
module multicycle_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic       instr_retire,
   output logic       illegal_instr
);

   state_t    r_state;
   state_t    w_next;
   ctrl_t     r_ctrl;
   op_class_t w_cls;

   ctrl_opcode_classify u_classify (
      .op  (op),
      .cls (w_cls)
   );

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH:    begin c.srcb = SRCB_FOUR; c.res = RES_ALURESULT; c.ir_rdy = 1'b1; c.pc_upd_rdy = 1'b1; end
         ST_DECODE:   begin c.srca = SRCA_OLDPC; c.srcb = SRCB_IMM; end
         ST_MEMADR:   begin c.srca = SRCA_RD1; c.srcb = SRCB_IMM; end
         ST_MEMREAD:  begin c.res = RES_ALUOUT; c.adr_src = 1'b1; end
         ST_MEMWB:    begin c.res = RES_DATA; c.reg_write = 1'b1; c.retire = 1'b1; end
         ST_MEMWRITE: begin c.res = RES_ALUOUT; c.adr_src = 1'b1; c.mem_write = 1'b1; c.retire_rdy = 1'b1; end
         ST_EXECR:    begin c.srca = SRCA_RD1; c.srcb = SRCB_WD; c.alu_op = ALUOP_FUNCT; end
         ST_EXECI:    begin c.srca = SRCA_RD1; c.srcb = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
         ST_ALUWB:    begin c.res = RES_ALUOUT; c.reg_write = 1'b1; c.retire = 1'b1; end
         ST_BEQ:      begin c.srca = SRCA_RD1; c.srcb = SRCB_WD; c.alu_op = ALUOP_SUB; c.branch = 1'b1; c.retire = 1'b1; end
         ST_JAL:      begin c.srca = SRCA_OLDPC; c.srcb = SRCB_FOUR; c.alu_op = ALUOP_ADD; c.pc_upd = 1'b1; end
         ST_TRAP:     c.illegal = 1'b1;
         default:     c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            if (w_cls.is_illegal)  w_next = ST_TRAP;
            else if (w_cls.is_mem) w_next = ST_MEMADR;
            else if (w_cls.is_r)   w_next = ST_EXECR;
            else if (w_cls.is_i)   w_next = ST_EXECI;
            else if (w_cls.is_beq) w_next = ST_BEQ;
            else                   w_next = ST_JAL;
         end
         // only lw/sw reach here, so is_store is exactly op[5]
         ST_MEMADR:   w_next = w_cls.is_store ? ST_MEMWRITE : ST_MEMREAD;
         ST_MEMREAD:  w_next = mem_ready ? ST_MEMWB : ST_MEMREAD;
         ST_MEMWB:    w_next = ST_FETCH;
         ST_MEMWRITE: w_next = mem_ready ? ST_FETCH : ST_MEMWRITE;
         ST_EXECR:    w_next = ST_ALUWB;
         ST_EXECI:    w_next = ST_ALUWB;
         ST_ALUWB:    w_next = ST_FETCH;
         ST_BEQ:      w_next = ST_FETCH;
         ST_JAL:      w_next = ST_ALUWB;
         ST_TRAP:     w_next = ST_TRAP;
         default:     w_next = ST_TRAP;
      endcase
   end

   // Control word is registered alongside the state so Moore outputs come straight from flops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= state_t'(RESET_STATE);
         r_ctrl  <= state_ctrl(state_t'(RESET_STATE));
      end else begin
         r_state <= w_next;
         r_ctrl  <= state_ctrl(w_next);
      end
   end

   assign PCWrite       = r_ctrl.pc_upd | (r_ctrl.pc_upd_rdy & mem_ready) | (r_ctrl.branch & Zero);
   assign IRWrite       = r_ctrl.ir_rdy & mem_ready;
   assign instr_retire  = r_ctrl.retire | (r_ctrl.retire_rdy & mem_ready);
   assign AdrSrc        = r_ctrl.adr_src;
   assign MemWrite      = r_ctrl.mem_write;
   assign ResultSrc     = r_ctrl.res;
   assign ALUSrcA       = r_ctrl.srca;
   assign ALUSrcB       = r_ctrl.srcb;
   assign ALUOp         = r_ctrl.alu_op;
   assign RegWrite      = r_ctrl.reg_write;
   assign illegal_instr = r_ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: an instruction-level phase model predicts
// every output each cycle under directed and randomized opcode / mem_ready / Zero stimulus.
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op = 7'd0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_retire, illegal_instr;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

   multicycle_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
      .clk(clk), .rst(rst), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegWrite(RegWrite), .instr_retire(instr_retire), .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   // Phases of one instruction: fetch, decode, address, mem-read wait, mem writeback,
   // store wait, exec R, exec I, ALU writeback, branch, jump, trap
   typedef enum int {P_F, P_D, P_A, P_R, P_MW, P_S, P_XR, P_XI, P_WB, P_B, P_J, P_T} ph_t;

   ph_t        cur = P_F;
   ph_t        plan[$];
   logic [6:0] pending_op = 7'd0;
   int         dir_op = -1;
   bit         started = 1'b0;
   int         tests = 0;
   int         fails = 0;

   function automatic bit is_legal(input logic [6:0] o);
      return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic start_instr();
      logic [6:0] o;
      int k;
      if (dir_op >= 0) o = dir_op[6:0];
      else begin
         k = $urandom_range(0, 9);
         case (k)
            0, 7:    o = 7'b0000011;
            1:       o = 7'b0100011;
            2, 8:    o = 7'b0110011;
            3:       o = 7'b0010011;
            4, 9:    o = 7'b1100011;
            5:       o = 7'b1101111;
            default: begin
               o = 7'($urandom);
               while (is_legal(o)) o = 7'($urandom);
            end
         endcase
      end
      pending_op = o;
      cur = P_F;
      plan.delete();
      case (o)
         7'b0000011: plan = {P_D, P_A, P_R, P_MW};
         7'b0100011: plan = {P_D, P_A, P_S};
         7'b0110011: plan = {P_D, P_XR, P_WB};
         7'b0010011: plan = {P_D, P_XI, P_WB};
         7'b1100011: plan = {P_D, P_B};
         7'b1101111: plan = {P_D, P_J, P_WB};
         default:    plan = {P_D, P_T};
      endcase
   endtask

   // Called at the active edge, before inputs move, so rst/mem_ready are the sampled values
   task automatic advance();
      if (rst) begin
         started = 1'b1;
         start_instr();
      end else if (cur == P_T) begin
         cur = P_T;
      end else if ((cur == P_F || cur == P_R || cur == P_S) && !mem_ready) begin
         cur = cur;
      end else if (plan.size() == 0) begin
         start_instr();
      end else begin
         cur = plan.pop_front();
      end
   endtask

   task automatic tick();
      @(posedge clk);
      advance();
      #1;
      op = pending_op;
   endtask

   always @(negedge clk) begin
      logic e_pcw, e_adr, e_mw, e_irw, e_rw, e_ret, e_ill;
      logic [1:0] e_res, e_a, e_b, e_op;
      if (started) begin
         {e_pcw, e_adr, e_mw, e_irw, e_rw, e_ret, e_ill} = '0;
         {e_res, e_a, e_b, e_op} = '0;
         case (cur)
            P_F:  begin e_b = 2'd2; e_res = 2'd2; e_irw = mem_ready; e_pcw = mem_ready; end
            P_D:  begin e_a = 2'd1; e_b = 2'd1; end
            P_A:  begin e_a = 2'd2; e_b = 2'd1; end
            P_R:  e_adr = 1'b1;
            P_MW: begin e_res = 2'd1; e_rw = 1'b1; e_ret = 1'b1; end
            P_S:  begin e_adr = 1'b1; e_mw = 1'b1; e_ret = mem_ready; end
            P_XR: begin e_a = 2'd2; e_op = 2'd2; end
            P_XI: begin e_a = 2'd2; e_b = 2'd1; e_op = 2'd2; end
            P_WB: begin e_rw = 1'b1; e_ret = 1'b1; end
            P_B:  begin e_a = 2'd2; e_op = 2'd1; e_ret = 1'b1; e_pcw = Zero; end
            P_J:  begin e_a = 2'd1; e_b = 2'd2; e_pcw = 1'b1; end
            P_T:  e_ill = 1'b1;
            default: ;
         endcase
         chk("PCWrite", PCWrite, e_pcw);
         chk("AdrSrc", AdrSrc, e_adr);
         chk("MemWrite", MemWrite, e_mw);
         chk("IRWrite", IRWrite, e_irw);
         chk("ResultSrc", ResultSrc, e_res);
         chk("ALUSrcA", ALUSrcA, e_a);
         chk("ALUSrcB", ALUSrcB, e_b);
         chk("ALUOp", ALUOp, e_op);
         chk("RegWrite", RegWrite, e_rw);
         chk("instr_retire", instr_retire, e_ret);
         chk("illegal_instr", illegal_instr, e_ill);
      end
   end

   // Reset, then run one instruction; report cycles up to and including the retire pulse
   task automatic run_dir(input logic [6:0] o, input int stalls, input logic z,
                          input int exp_n, input string name);
      int n;
      int st;
      st = stalls;
      dir_op = int'(o);
      rst = 1'b1;
      mem_ready = 1'b0;
      Zero = z;
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
      n = 1;
      while (n <= 40) begin
         @(negedge clk);
         if (n == 1) chk({name, "_fetch_irw"}, IRWrite, 1'b1);
         if (instr_retire) break;
         tick();
         mem_ready = !(cur == P_R && st > 0);
         if (cur == P_R && st > 0) st--;
         n++;
      end
      chk({name, "_cycles"}, n, exp_n);
      if (o == 7'b1100011) chk({name, "_pcw"}, PCWrite, z);
   endtask

   initial begin
      int trap_cnt;
      int k;
      rst = 1'b1;
      mem_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_enables", {PCWrite, IRWrite, MemWrite, RegWrite, instr_retire, illegal_instr}, 6'b0);
      chk("rst_srcb", ALUSrcB, 2'b10);
      chk("rst_res", ResultSrc, 2'b10);

      run_dir(7'b0110011, 0, 1'b0, 4, "rtype");
      run_dir(7'b0010011, 0, 1'b0, 4, "itype");
      run_dir(7'b0000011, 0, 1'b0, 5, "lw");
      run_dir(7'b0000011, 3, 1'b0, 8, "lw_stall3");
      run_dir(7'b0100011, 0, 1'b0, 4, "sw");
      run_dir(7'b1100011, 0, 1'b1, 3, "beq_taken");
      run_dir(7'b1100011, 0, 1'b0, 3, "beq_not");
      run_dir(7'b1101111, 0, 1'b0, 4, "jal");

      // Unsupported opcode traps and holds until reset
      dir_op = 7'h7F;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
      repeat (13) tick();
      @(negedge clk);
      chk("trap_flag", illegal_instr, 1'b1);
      chk("trap_enables", {PCWrite, IRWrite, MemWrite, RegWrite, instr_retire}, 5'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("trap_cleared", illegal_instr, 1'b0);

      // Reset during a stalled store
      dir_op = 7'b0100011;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
      k = 0;
      while (cur != P_S && k < 10) begin
         tick();
         mem_ready = (cur != P_S);
         k++;
      end
      chk("sw_reached", k < 10, 1'b1);
      tick();
      tick();
      @(negedge clk);
      chk("sw_stall_memwrite", MemWrite, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("sw_rst_memwrite", MemWrite, 1'b0);

      // Randomized traffic
      dir_op = -1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      trap_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (cur == P_T) trap_cnt++;
         else trap_cnt = 0;
         rst       = (trap_cnt > 5) || ($urandom_range(0, 99) == 0);
         mem_ready = ($urandom_range(0, 2) != 0);
         Zero      = $urandom_range(0, 1) != 0;
      end
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the multi-cycle RV32I core variant. It sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction. It drives the datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU decoder. It waits on a memory-ready handshake and traps permanently on unsupported opcodes.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  instruction opcode bits [6:0], from the instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory port has completed the current access this cycle
- PCWrite  out  1  PC register enable; equals PCUpdate | (Branch & Zero)
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- RegWrite  out  1  register file write enable
- instr_retire  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_instr  out  1  sticky trap flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP. Encoding is 4 bits, registered. Outputs are Moore, except PCWrite/IRWrite gating by mem_ready and PCWrite's dependence on Zero.
- Reset (rst=1 at clk edge): state = FETCH, illegal_instr = 0. With the FETCH decode active and mem_ready low, all enables are 0 (PCWrite, IRWrite, MemWrite, RegWrite, instr_retire). Selects take their FETCH values. rst overrides every state, including TRAP and mid-wait states.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - Holds while mem_ready=0.
  - When mem_ready=1: IRWrite=1, PCUpdate=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_retire=1. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held for the whole wait. When mem_ready: instr_retire=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_retire=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_retire=1. PCWrite=Zero in that cycle. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB (writes PC+4 to rd).
- TRAP: all enables 0, illegal_instr=1. Stays in TRAP until rst.
- Latencies with mem_ready tied high:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- Each mem_ready=0 cycle in a wait state adds one cycle.
- In every non-wait state mem_ready is ignored.
- ALUOp is never 11. Don't-care selects are driven to 00 (no X on outputs).

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - state encoding localparams
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - mux-select constants: SRCA_*, SRCB_*, RES_*
- One natural sub-module: ctrl_opcode_classify (combinational op -> {is_mem, is_store, is_r, is_i, is_beq, is_jal, is_illegal}), shared with a later pipelined decode.
- The FSM register, next-state logic and output decode stay in this module.

Test Plan:
- rst=1 for 2 cycles then release, mem_ready=1 -> state FETCH. All enables 0 during reset; IRWrite=1 and PCWrite=1 on the first cycle after release.
- R-type op=0110011, mem_ready=1 -> sequence FETCH, DECODE, EXECR, ALUWB. ALUOp=10 in EXECR; RegWrite=1 and instr_retire=1 only in cycle 4.
- lw op=0000011 with mem_ready low for 3 cycles in MEMREAD -> 8 total cycles. RegWrite=1 with ResultSrc=01 exactly once. AdrSrc=1 throughout MEMREAD.
- beq op=1100011: with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0. Both take 3 cycles with ALUOp=01.
- jal op=1101111 -> PCWrite=1 in JAL, then RegWrite=1 with ALUSrcB irrelevant in ALUWB; 4 cycles total.
- op=1111111 -> TRAP after DECODE. illegal_instr=1 and all enables stay 0 for 10 cycles. rst=1 returns to FETCH with illegal_instr=0. Also assert rst while MEMWRITE is stalling -> MemWrite drops to 0 the next cycle.
